// File: rtl/handshake_constant_check_if.sv
// Valid/ready bundle between a constant-carrying data edge and the dataless control edge.
// slave = the checker side, master = whoever drives tokens in and drains control out.
interface handshake_constant_check_if #(
    parameter int DATA_WIDTH = 32
) ();
    // Handshake rule for both channels: a transfer happens on a rising edge where
    // valid and ready are both 1; once valid is raised, it and its payload hold
    // until that transfer.
    logic [DATA_WIDTH-1:0] ins;
    logic                  ins_valid;
    logic                  ins_ready;
    logic                  ctrl_valid;
    logic                  ctrl_ready;
    logic                  ctrl_match;

    modport slave (
        input  ins,
        input  ins_valid,
        output ins_ready,
        output ctrl_valid,
        input  ctrl_ready,
        output ctrl_match
    );

    modport master (
        output ins,
        output ins_valid,
        input  ins_ready,
        input  ctrl_valid,
        output ctrl_ready,
        input  ctrl_match
    );
endinterface

// File: rtl/handshake_constant_check.sv
// Sink for a constant dataflow edge: compares each token with CONST_VALUE, returns a match flag
// through a registered 2-entry elastic stage, and keeps saturating counters. Optional clr: HANDSHAKE_CONST_CHECK_CLR_EN.
module handshake_constant_check #(
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] CONST_VALUE = 32'h3C5A0F12,
    parameter int          COUNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef HANDSHAKE_CONST_CHECK_CLR_EN
    input  logic                        clr,
`endif
    handshake_constant_check_if.slave   hs,
    output logic [COUNT_WIDTH-1:0]      token_count,
    output logic [COUNT_WIDTH-1:0]      mismatch_count,
    output logic                        error,
    output logic [1:0]                  o_state
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0]  C_CONST = DATA_WIDTH'(CONST_VALUE);
    localparam logic [COUNT_WIDTH-1:0] C_ONE   = COUNT_WIDTH'(1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_main;
    logic                   r_skid;
    logic                   w_main_d;
    logic                   w_skid_d;
    logic                   r_ins_ready;
    logic                   r_ctrl_valid;
    logic [COUNT_WIDTH-1:0] r_token_count;
    logic [COUNT_WIDTH-1:0] r_mismatch_count;
    logic                   r_error;
    logic                   w_match;
    logic                   w_accept;
    logic                   w_drain;
    logic                   w_clr;

`ifdef HANDSHAKE_CONST_CHECK_CLR_EN
    assign w_clr = clr;
`else
    assign w_clr = 1'b0;
`endif

    // Only the 1-bit result is kept; the data word itself is dropped after the compare.
    assign w_match  = (hs.ins == C_CONST);
    assign w_accept = hs.ins_valid & r_ins_ready;
    assign w_drain  = r_ctrl_valid & hs.ctrl_ready;

    always_comb begin
        w_next_state = r_state;
        w_main_d     = r_main;
        w_skid_d     = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next_state = ST_ONE;
                    w_main_d     = w_match;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_drain) begin
                    w_next_state = ST_TWO;
                    w_skid_d     = w_match;
                end else if (!w_accept && w_drain) begin
                    w_next_state = ST_EMPTY;
                    w_main_d     = 1'b0;
                end else if (w_accept && w_drain) begin
                    w_main_d     = w_match;
                end
            end
            ST_TWO: begin
                // ins_ready is low here, so the only possible event is a drain.
                if (w_drain) begin
                    w_next_state = ST_ONE;
                    w_main_d     = r_skid;
                end
            end
            default: begin
                w_next_state = ST_EMPTY;
                w_main_d     = 1'b0;
            end
        endcase
    end

    // Ready and valid are flopped from the next state so neither depends combinationally on the other side.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_EMPTY;
            r_main       <= 1'b0;
            r_skid       <= 1'b0;
            r_ins_ready  <= 1'b1;
            r_ctrl_valid <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_main       <= w_main_d;
            r_skid       <= w_skid_d;
            r_ins_ready  <= (w_next_state != ST_TWO);
            r_ctrl_valid <= (w_next_state != ST_EMPTY);
        end
    end

    // Statistics track accepted tokens; clr beats a same-edge accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_token_count    <= '0;
            r_mismatch_count <= '0;
            r_error          <= 1'b0;
        end else if (w_clr) begin
            r_token_count    <= '0;
            r_mismatch_count <= '0;
            r_error          <= 1'b0;
        end else if (w_accept) begin
            if (!(&r_token_count)) begin
                r_token_count <= r_token_count + C_ONE;
            end
            if (!w_match) begin
                r_error <= 1'b1;
                if (!(&r_mismatch_count)) begin
                    r_mismatch_count <= r_mismatch_count + C_ONE;
                end
            end
        end
    end

    assign hs.ins_ready    = r_ins_ready;
    assign hs.ctrl_valid   = r_ctrl_valid;
    assign hs.ctrl_match   = r_main;
    assign token_count     = r_token_count;
    assign mismatch_count  = r_mismatch_count;
    assign error           = r_error;
    assign o_state         = r_state;

endmodule

// File: tb/tb_handshake_constant_check.sv
// Directed bench for handshake_constant_check: a per-cycle vector table plus hand-written
// sequences for sticky error, throughput, saturation, async reset and the optional clr.
module tb_handshake_constant_check;

    localparam logic [31:0] C_OK   = 32'h3C5A0F12;
    localparam logic [31:0] C_BAD0 = 32'h00000000;
    localparam logic [31:0] C_BAD1 = 32'h3C5A0F13;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    handshake_constant_check_if #(.DATA_WIDTH(32)) hs ();
    handshake_constant_check_if #(.DATA_WIDTH(32)) hs4 ();

    logic [15:0] tc, mc;
    logic        err;
    logic [1:0]  st;
    logic [3:0]  tc4, mc4;
    logic        err4;
    logic [1:0]  st4;

    handshake_constant_check #(
        .DATA_WIDTH(32), .CONST_VALUE(C_OK), .COUNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef HANDSHAKE_CONST_CHECK_CLR_EN
        .clr(clr),
`endif
        .hs(hs.slave), .token_count(tc), .mismatch_count(mc), .error(err), .o_state(st)
    );

    handshake_constant_check #(
        .DATA_WIDTH(32), .CONST_VALUE(C_OK), .COUNT_WIDTH(4)
    ) dut4 (
        .clk(clk), .rst(rst),
`ifdef HANDSHAKE_CONST_CHECK_CLR_EN
        .clr(clr),
`endif
        .hs(hs4.slave), .token_count(tc4), .mismatch_count(mc4), .error(err4), .o_state(st4)
    );

    typedef struct {
        logic        v;
        logic [31:0] din;
        logic        rdy;
        logic        e_valid;
        logic        e_match;
        logic        e_ready;
        logic [15:0] e_tc;
        logic [15:0] e_mc;
        logic        e_err;
    } vec_t;

    vec_t vecs[14];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] din, input logic rdy);
        hs.ins_valid  = v;
        hs.ins        = din;
        hs.ctrl_ready = rdy;
    endtask

    task automatic drive4(input logic v, input logic [31:0] din, input logic rdy);
        hs4.ins_valid  = v;
        hs4.ins        = din;
        hs4.ctrl_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, C_OK, 1'b1);
        drive4(1'b0, C_OK, 1'b1);
        clr = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int drained;
        int ready_low;
        int bad_match;

        // v, din, rdy | valid, match, ready, token_count, mismatch_count, error
        vecs[0]  = '{1'b1, C_OK,   1'b1, 1'b1, 1'b1, 1'b1, 16'd1, 16'd0, 1'b0};
        vecs[1]  = '{1'b0, C_OK,   1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0, 1'b0};
        vecs[2]  = '{1'b1, C_BAD0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2, 16'd1, 1'b1};
        vecs[3]  = '{1'b0, C_OK,   1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 16'd1, 1'b1};
        vecs[4]  = '{1'b1, C_OK,   1'b0, 1'b1, 1'b1, 1'b1, 16'd3, 16'd1, 1'b1};
        vecs[5]  = '{1'b1, C_BAD0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd4, 16'd2, 1'b1};
        vecs[6]  = '{1'b1, C_OK,   1'b0, 1'b1, 1'b1, 1'b0, 16'd4, 16'd2, 1'b1};
        vecs[7]  = '{1'b1, C_OK,   1'b1, 1'b1, 1'b0, 1'b1, 16'd4, 16'd2, 1'b1};
        vecs[8]  = '{1'b1, C_OK,   1'b1, 1'b1, 1'b1, 1'b1, 16'd5, 16'd2, 1'b1};
        vecs[9]  = '{1'b0, C_OK,   1'b1, 1'b0, 1'b0, 1'b1, 16'd5, 16'd2, 1'b1};
        vecs[10] = '{1'b0, C_OK,   1'b0, 1'b0, 1'b0, 1'b1, 16'd5, 16'd2, 1'b1};
        vecs[11] = '{1'b1, C_BAD1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd6, 16'd3, 1'b1};
        vecs[12] = '{1'b0, C_OK,   1'b0, 1'b1, 1'b0, 1'b1, 16'd6, 16'd3, 1'b1};
        vecs[13] = '{1'b0, C_OK,   1'b1, 1'b0, 1'b0, 1'b1, 16'd6, 16'd3, 1'b1};

        // Reset values
        do_reset();
        chk("rst_ctrl_valid", hs.ctrl_valid, 0);
        chk("rst_ctrl_match", hs.ctrl_match, 0);
        chk("rst_ins_ready",  hs.ins_ready, 1);
        chk("rst_token_count", tc, 0);
        chk("rst_mismatch_count", mc, 0);
        chk("rst_error", err, 0);
        chk("rst_state", st, 0);
        chk("rst_state4", st4, 0);
        chk("rst_ins_ready4", hs4.ins_ready, 1);

        // Per-cycle vector table: single tokens, stall to full, drain order 1,0,1
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].din, vecs[i].rdy);
            step();
            chk($sformatf("vec%0d_ctrl_valid", i), hs.ctrl_valid, vecs[i].e_valid);
            if (vecs[i].e_valid)
                chk($sformatf("vec%0d_ctrl_match", i), hs.ctrl_match, vecs[i].e_match);
            chk($sformatf("vec%0d_ins_ready", i), hs.ins_ready, vecs[i].e_ready);
            chk($sformatf("vec%0d_token_count", i), tc, vecs[i].e_tc);
            chk($sformatf("vec%0d_mismatch_count", i), mc, vecs[i].e_mc);
            chk($sformatf("vec%0d_error", i), err, vecs[i].e_err);
        end

        // Sticky error across 10 following matching tokens
        do_reset();
        drive(1'b1, C_BAD0, 1'b1);
        step();
        chk("sticky_first_error", err, 1);
        chk("sticky_first_match", hs.ctrl_match, 0);
        drive(1'b1, C_OK, 1'b1);
        repeat (10) step();
        drive(1'b0, C_OK, 1'b1);
        step();
        chk("sticky_error_hold", err, 1);
        chk("sticky_token_count", tc, 11);
        chk("sticky_mismatch_count", mc, 1);

        // Full throughput: 100 tokens in 101 cycles with ins_ready never low
        do_reset();
        drained = 0;
        ready_low = 0;
        bad_match = 0;
        drive(1'b1, C_OK, 1'b1);
        for (int i = 0; i <= 100; i++) begin
            if (i == 100) drive(1'b0, C_OK, 1'b1);
            if (hs.ctrl_valid && hs.ctrl_ready) begin
                drained++;
                if (hs.ctrl_match !== 1'b1) bad_match++;
            end
            if (hs.ins_ready !== 1'b1) ready_low++;
            step();
        end
        chk("thru_drained", drained, 100);
        chk("thru_ready_low", ready_low, 0);
        chk("thru_bad_match", bad_match, 0);
        chk("thru_token_count", tc, 100);
        chk("thru_ctrl_valid_end", hs.ctrl_valid, 0);

        // Saturation with a 4-bit counter
        do_reset();
        drive4(1'b1, C_BAD0, 1'b1);
        repeat (20) step();
        drive4(1'b0, C_OK, 1'b1);
        step();
        chk("sat_token_count", tc4, 15);
        chk("sat_mismatch_count", mc4, 15);
        chk("sat_error", err4, 1);

        // Asynchronous reset with two tokens buffered
        do_reset();
        drive(1'b1, C_OK, 1'b0);
        step();
        drive(1'b1, C_BAD0, 1'b0);
        step();
        chk("full_ins_ready", hs.ins_ready, 0);
        chk("full_state", st, 2);
        chk("full_token_count", tc, 2);
        drive(1'b0, C_OK, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_ctrl_valid", hs.ctrl_valid, 0);
        chk("arst_ins_ready", hs.ins_ready, 1);
        chk("arst_token_count", tc, 0);
        chk("arst_mismatch_count", mc, 0);
        chk("arst_error", err, 0);
        chk("arst_state", st, 0);
        step();
        rst = 1'b1;
        step();
        chk("arst_no_ghost_token", hs.ctrl_valid, 0);
        drive(1'b1, C_OK, 1'b1);
        step();
        drive(1'b0, C_OK, 1'b1);
        chk("arst_resume_valid", hs.ctrl_valid, 1);
        chk("arst_resume_match", hs.ctrl_match, 1);
        chk("arst_resume_count", tc, 1);

`ifdef HANDSHAKE_CONST_CHECK_CLR_EN
        // clr coincident with a mismatching accept
        do_reset();
        drive(1'b1, C_BAD0, 1'b1);
        step();
        chk("clr_pre_error", err, 1);
        chk("clr_pre_count", tc, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        drive(1'b0, C_OK, 1'b1);
        chk("clr_token_count", tc, 0);
        chk("clr_mismatch_count", mc, 0);
        chk("clr_error", err, 0);
        chk("clr_ctrl_valid", hs.ctrl_valid, 1);
        chk("clr_ctrl_match", hs.ctrl_match, 0);
        step();
        chk("clr_drained", hs.ctrl_valid, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/handshake_constant_check.md
Name: handshake_constant_check

Overview:
- Consumer-side counterpart of the handshake constant source.
- Accepts a data token on a valid/ready channel and checks it against a compile-time constant.
- Returns one dataless control token per accepted data token. The control token carries a match flag.
- Sits at the sink end of a constant-producing dataflow edge. Used as a self-checking terminator and as a token-to-control converter, with a registered 2-entry elastic stage so timing is cut on both valid and ready.

Parameters:
- DATA_WIDTH, 32, width of the incoming data token.
- CONST_VALUE, 32'h3C5A0F12, expected token value; only DATA_WIDTH LSBs are used.
- COUNT_WIDTH, 16, width of the saturating token and mismatch counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ins  in  DATA_WIDTH  incoming data token.
- ins_valid  in  1  data token valid.
- ins_ready  out  1  block can accept a token.
- ctrl_valid  out  1  control token valid.
- ctrl_ready  in  1  downstream accepts the control token.
- ctrl_match  out  1  payload of the control token: 1 if the consumed ins equalled CONST_VALUE.
- token_count  out  COUNT_WIDTH  saturating count of accepted tokens.
- mismatch_count  out  COUNT_WIDTH  saturating count of accepted tokens with ctrl_match=0.
- error  out  1  sticky; set on the first mismatch.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While rst=0, all state clears immediately, with no clock needed.
- Reset values: ctrl_valid=0, ctrl_match=0, ins_ready=1 (buffer empty), token_count=0, mismatch_count=0, error=0.
- Accept: a data token is accepted on a rising edge where ins_valid=1 and ins_ready=1. The compare is combinational on ins. Only the 1-bit match result is stored; the data itself is dropped.
- Elastic stage: two entries, main and skid. The stage holds three states:
  - EMPTY: ctrl_valid=0, ins_ready=1.
    - accept -> ONE.
  - ONE: ctrl_valid=1, ins_ready=1.
    - accept with no drain -> TWO (new match goes to skid).
    - drain with no accept -> EMPTY.
    - accept and drain together -> ONE (new match goes to main).
  - TWO: ctrl_valid=1, ins_ready=0.
    - drain -> ONE (skid moves to main).
    - No accept is possible in TWO.
- ins_ready is a registered output: it depends only on state, not on ins_valid or ctrl_ready.
- Latency: accept at edge N gives ctrl_valid=1 from cycle N+1. No bubbles: sustained throughput is 1 token/cycle when ctrl_ready is held at 1.
- Ordering: control tokens leave strictly in acceptance order.
- ctrl_match is stable while ctrl_valid=1 and ctrl_ready=0. ctrl_valid must not drop without a transfer.
- Counters update on the accept edge:
  - token_count += 1.
  - mismatch_count += 1 if the compare failed.
  - Both saturate at 2^COUNT_WIDTH-1 and do not wrap.
- error is set on the accept edge of any mismatch and stays set until reset.
- Counters and error count accepted tokens, not drained control tokens.
- Reset mid-operation: tokens in flight are discarded, no control token is emitted for them, and counters clear. After reset is released, the block resumes from EMPTY.

Optional Feature:
- Macro: HANDSHAKE_CONST_CHECK_CLR_EN.
- When defined, an extra input port clr (1 bit, synchronous, active-high) is present. On a clock edge with clr=1:
  - token_count, mismatch_count and error are cleared.
  - The elastic stage and its in-flight tokens are unaffected.
  - If an accept occurs on the same edge, clr wins: counters read 0 after that edge, and the token is still forwarded.
- When the macro is undefined, no clr port exists. Counters and error clear only on rst.

Test Plan:
- Reset, then send ins=32'h3C5A0F12 with ins_valid=1 for one cycle and ctrl_ready=1 -> ctrl_valid=1 one cycle later with ctrl_match=1; token_count=1, mismatch_count=0, error=0.
- Send ins=32'h00000000 once -> ctrl_match=0; mismatch_count=1; error=1 and stays 1 after 10 further matching tokens (token_count=11).
- ctrl_ready=0, send 3 back-to-back tokens (match, mismatch, match) -> ins_ready=0 after 2 accepts and the third is stalled. Then release ctrl_ready=1 -> ctrl_match sequence 1,0,1 with no reordering or loss; total token_count=3.
- Drive ins_valid=1 and ctrl_ready=1 continuously for 100 cycles -> 100 control tokens delivered in 101 cycles, ins_ready never deasserted.
- COUNT_WIDTH=4, send 20 mismatching tokens -> token_count=mismatch_count=15 (saturated, no wrap).
- Assert rst=0 asynchronously with two tokens buffered -> ctrl_valid=0 and ins_ready=1 immediately, counters=0. With HANDSHAKE_CONST_CHECK_CLR_EN defined: clr=1 coincident with a mismatching accept -> counters 0 and error 0 after that edge, and the control token is still emitted with ctrl_match=0.
